wl_sort3: RTL and testbench
===========================

WL_SORT3 -- requirements
Module: wl_sort3

Interface
REQ-001 Parameter DW, default 8, bit width of each unsigned element.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_b  input  1  reset, asynchronous, active-low.
REQ-004 din  input  3*DW  three packed unsigned elements: E2=din[3*DW-1:2*DW], E1=din[2*DW-1:DW], E0=din[DW-1:0].
REQ-005 dout  output  3*DW  sorted result, registered: dout[3*DW-1:2*DW]=max, dout[2*DW-1:DW]=median, dout[DW-1:0]=min.
REQ-006 No other ports: no valid or ready handshake; din is sampled on every clock edge.

Function
REQ-007 The block SHALL sort the three din elements into descending order, with max in the MSB field as per REQ-005.
REQ-008 Comparisons SHALL be unsigned magnitude over the full DW bits.
REQ-009 The sorter SHALL be a three-stage registered compare-swap network:
  - stage 1: order (E2,E1);
  - stage 2: order (stage-1 low, E0);
  - stage 3: order (stage-2 two upper fields).
  Each stage swaps two fields only if the lower-positioned field is strictly greater.
REQ-010 Latency SHALL be exactly 3 clk cycles: din sampled at edge N appears on dout after edge N+2, stable for cycle N+3.
REQ-011 Throughput SHALL be one result per cycle, with back-to-back independent inputs supported.
REQ-012 Equal elements SHALL yield identical output fields, and no swap occurs on equality.
REQ-013 The output SHALL be a permutation of the input elements: no saturation, arithmetic or width growth.
REQ-014 Pipeline data SHALL be carried unchanged between stages except for swaps; every stage holds all 3*DW bits.
REQ-015 All internal pipeline registers and dout SHALL be flip-flops; no combinational path from din to dout.
REQ-016 Boundary cases:
  - all-zero input -> all-zero output;
  - all-max input (2^DW-1 each) -> unchanged;
  - already-descending input -> unchanged;
  - ascending input -> fully reversed.

Reset
REQ-017 While rst_b=0, every pipeline register and dout SHALL be 0, asynchronously, regardless of clk.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight data immediately.
REQ-019 After rst_b deasserts, dout SHALL show 0 until the first post-reset sample emerges 3 cycles later.
REQ-020 Reset deassertion SHALL be treated as synchronous to clk by the surrounding system; no internal synchronizer.

Verification (DW=8)
REQ-021 Reset check: rst_b=0 with any din -> dout=0 at once; hold for 5 cycles, then release -> dout=0 until the first sample arrives.
REQ-022 Equal and already-sorted inputs, each held 5 cycles:
  - din={255,255,255} -> dout={255,255,255} 3 cycles after sampling;
  - din={255,254,253} -> dout={255,254,253}.
REQ-023 Truncated-literal input: din={255,0,253} (a 256 literal truncates to 0) -> dout={255,253,0}.
REQ-024 Unsorted inputs:
  - din={254,253,255} -> dout={255,254,253};
  - din={250,253,255} -> dout={255,253,250};
  - din={252,253,254} -> dout={254,253,252}.
REQ-025 Pipeline checks:
  - changing din every cycle with random values -> each dout equals the descending sort of din from 3 cycles earlier;
  - asserting rst_b=0 mid-stream -> dout=0 immediately, with no stale results after release.

Source files
------------

// File: rtl/wl_sort3.sv
// Three-element unsigned sorter: a three-stage registered compare-swap pipeline.
// Produces descending order (max in the MSB field) with 3-cycle latency.
module wl_sort3 #(
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [3*DW-1:0] din,
  output logic [3*DW-1:0] dout
);

  localparam int unsigned W = 3 * DW;

  logic [W-1:0] s1_d, s1_q;
  logic [W-1:0] s2_d, s2_q;
  logic [W-1:0] s3_d;

  // Stage 1: order (E2, E1); swap only when the lower field is strictly greater.
  always_comb begin
    s1_d = din;
    if (din[2*DW-1:DW] > din[3*DW-1:2*DW]) begin
      s1_d = {din[2*DW-1:DW], din[3*DW-1:2*DW], din[DW-1:0]};
    end
  end

  // Stage 2: order (stage-1 low, E0), pushing the minimum into the LSB field.
  always_comb begin
    s2_d = s1_q;
    if (s1_q[DW-1:0] > s1_q[2*DW-1:DW]) begin
      s2_d = {s1_q[3*DW-1:2*DW], s1_q[DW-1:0], s1_q[2*DW-1:DW]};
    end
  end

  // Stage 3: order the two upper fields to settle max and median.
  always_comb begin
    s3_d = s2_q;
    if (s2_q[2*DW-1:DW] > s2_q[3*DW-1:2*DW]) begin
      s3_d = {s2_q[2*DW-1:DW], s2_q[3*DW-1:2*DW], s2_q[DW-1:0]};
    end
  end

  // Pipeline registers; reset clears every stage so no in-flight data survives.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1_q <= '0;
      s2_q <= '0;
      dout <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      dout <= s3_d;
    end
  end

endmodule

// File: tb/tb_wl_sort3.sv
// Directed and streaming checks for wl_sort3 (DW=8): reset, boundaries, latency, mid-stream reset.
module tb_wl_sort3;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 3 * DW;

  logic         clk;
  logic         rst_b;
  logic [W-1:0] din;
  logic [W-1:0] dout;

  int total;
  int fails;
  logic [W-1:0] exp_hist [$];

  wl_sort3 #(.DW(DW)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack3(input int e2, input int e1, input int e0);
    return {DW'(e2), DW'(e1), DW'(e0)};
  endfunction

  // Reference: max and min by direct comparison, median by elimination through the sum.
  function automatic logic [W-1:0] sort3(input logic [W-1:0] v);
    int a, b, c, mx, mn, md;
    a = int'(v[3*DW-1:2*DW]);
    b = int'(v[2*DW-1:DW]);
    c = int'(v[DW-1:0]);
    mx = a; if (b > mx) mx = b; if (c > mx) mx = c;
    mn = a; if (b < mn) mn = b; if (c < mn) mn = c;
    md = a + b + c - mx - mn;
    return pack3(mx, md, mn);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply a vector at a negedge, hold it 5 cycles, check the last 3 (settled) cycles.
  task automatic apply_hold(input string tag, input logic [W-1:0] vec, input logic [W-1:0] exp);
    din = vec;
    repeat (2) @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      check(tag, dout, exp);
    end
  endtask

  initial begin
    total = 0;
    fails = 0;
    rst_b = 1'b1;
    din   = pack3(17, 200, 99);

    // Asynchronous reset before any clock edge.
    #1 rst_b = 1'b0;
    #1 check("reset_async", dout, '0);
    repeat (5) begin
      @(negedge clk);
      check("reset_hold", dout, '0);
    end

    // Release with all-max input: zeros until the first sample emerges.
    rst_b = 1'b1;
    din   = pack3(255, 255, 255);
    @(negedge clk); check("post_reset_c1", dout, '0);
    @(negedge clk); check("post_reset_c2", dout, '0);
    repeat (3) begin
      @(negedge clk);
      check("all_max", dout, pack3(255, 255, 255));
    end

    apply_hold("sorted_desc",  pack3(255, 254, 253), pack3(255, 254, 253));
    apply_hold("trunc_lit",    pack3(255, 256, 253), pack3(255, 253, 0));
    apply_hold("unsorted_a",   pack3(254, 253, 255), pack3(255, 254, 253));
    apply_hold("unsorted_b",   pack3(250, 253, 255), pack3(255, 253, 250));
    apply_hold("ascending_a",  pack3(252, 253, 254), pack3(254, 253, 252));
    apply_hold("all_zero",     pack3(0, 0, 0),       pack3(0, 0, 0));
    apply_hold("ascending_b",  pack3(1, 2, 3),       pack3(3, 2, 1));
    apply_hold("dup_mid_max",  pack3(5, 9, 5),       pack3(9, 5, 5));
    apply_hold("dup_low",      pack3(7, 7, 8),       pack3(8, 7, 7));
    apply_hold("lone_max_mid", pack3(0, 255, 0),     pack3(255, 0, 0));
    apply_hold("msb_compare",  pack3(127, 128, 1),   pack3(128, 127, 1));

    // Back-to-back random stream: each result equals the sort of din from 3 cycles earlier.
    exp_hist.delete();
    for (int i = 0; i < 40; i++) begin
      if (i >= 3) check("stream", dout, exp_hist[i-3]);
      din = W'($urandom);
      exp_hist.push_back(sort3(din));
      @(negedge clk);
    end

    // Mid-stream reset clears output at once; no stale data after release.
    din   = W'($urandom);
    #2 rst_b = 1'b0;
    #1 check("midstream_reset", dout, '0);
    @(negedge clk); check("midstream_hold", dout, '0);
    rst_b = 1'b1;
    exp_hist.delete();
    for (int i = 0; i < 12; i++) begin
      if (i < 2)  check("no_stale", dout, '0);
      if (i >= 3) check("restream", dout, exp_hist[i-3]);
      din = W'($urandom);
      exp_hist.push_back(sort3(din));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
